// File: rtl/regfile_mp_if.sv
// Register file access bundle: read, write, allocate, flush and sweep-control signals.
// Latency: none of its own; this is pure wiring between issue/writeback and the register file.
// Backpressure: none. The register file accepts every request on every cycle.
// Ports: master = requester side (decode/issue/writeback). slave = regfile_mp.
interface regfile_mp_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRP   = 2,
   parameter int NWP   = 2
);
   localparam int AW = $clog2(NREGS);

   logic [NRP*AW-1:0]   rd_addr;
   logic [NRP*XLEN-1:0] rd_data;
   logic [NRP-1:0]      rd_busy;
   logic [NWP-1:0]      wr_en;
   logic [NWP*AW-1:0]   wr_addr;
   logic [NWP*XLEN-1:0] wr_data;
   logic                alloc_en;
   logic [AW-1:0]       alloc_addr;
   logic                flush;
   logic                sweep_req;
   logic                sweep_busy;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush, sweep_req,
      input  rd_data, rd_busy, sweep_busy
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush, sweep_req,
      output rd_data, rd_busy, sweep_busy
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, a pending-writeback scoreboard and a zeroing sweep.
// Latency: reads are combinational (same-cycle forwarding when BYPASS=1). Writes and allocs commit on the next edge.
// Backpressure: none. Every write and alloc is taken every cycle, and the sweep runs alongside normal traffic.
// Ports: clk, reset_n (async, active-low), bus (regfile_mp_if.slave). Read port j and write port i each occupy
//        slice [j*W +: W] of the packed bus vectors.
module regfile_mp #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRP    = 2,
   parameter int NWP    = 2,
   parameter bit BYPASS = 1'b1
) (
   input  logic          clk,
   input  logic          reset_n,
   regfile_mp_if.slave   bus
);
   localparam int AW = $clog2(NREGS);

   typedef enum logic {IDLE, SWEEP} state_t;

   logic [XLEN-1:0]  regs   [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;

   state_t           state;
   logic [AW-1:0]    idx;
   logic             sweep_busy_q;

   // Per-register write resolution. Ports are scanned in ascending order,
   // so the highest-index enabled port targeting a register wins.
   logic [NREGS-1:0] wr_hit;
   logic [XLEN-1:0]  wr_val [NREGS];

   always_comb begin
      for (int k = 0; k < NREGS; k++) begin
         wr_hit[k] = 1'b0;
         wr_val[k] = '0;
         for (int i = 0; i < NWP; i++) begin
            if (bus.wr_en[i] && (bus.wr_addr[i*AW +: AW] == AW'(k))) begin
               wr_hit[k] = 1'b1;
               wr_val[k] = bus.wr_data[i*XLEN +: XLEN];
            end
         end
      end
   end

   // Register storage. Entry 0 is only ever reset, so it stays zero.
   // An external write outranks the sweep zeroing the same entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NREGS; k++) regs[k] <= '0;
      end else begin
         for (int k = 1; k < NREGS; k++) begin
            if (wr_hit[k])
               regs[k] <= wr_val[k];
            else if ((state == SWEEP) && (idx == AW'(k)))
               regs[k] <= '0;
         end
      end
   end

   // Scoreboard next state, in rising order of precedence:
   // write/sweep clear, then a new alloc sets, then flush clears everything.
   always_comb begin
      busy_nxt = busy;
      for (int k = 0; k < NREGS; k++) begin
         if (wr_hit[k]) busy_nxt[k] = 1'b0;
         if ((state == SWEEP) && (idx == AW'(k))) busy_nxt[k] = 1'b0;
         if (bus.alloc_en && (bus.alloc_addr == AW'(k))) busy_nxt[k] = 1'b1;
      end
      if (bus.flush) busy_nxt = '0;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) busy <= '0;
      else          busy <= busy_nxt;
   end

   // Sweep FSM. sweep_busy is registered alongside the state, so it is high
   // for exactly NREGS cycles starting the cycle after sweep_req is sampled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         idx          <= '0;
         sweep_busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.sweep_req) begin
                  state        <= SWEEP;
                  idx          <= '0;
                  sweep_busy_q <= 1'b1;
               end
            end
            SWEEP: begin
               idx <= idx + AW'(1);
               if (idx == AW'(NREGS - 1)) begin
                  state        <= IDLE;
                  sweep_busy_q <= 1'b0;
               end
            end
            default: begin
               state        <= IDLE;
               sweep_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sweep_busy = sweep_busy_q;

   // Read ports. Forwarding reuses the resolved write view. A forwarded write
   // hides the busy bit unless an alloc re-marks the same register this cycle.
   for (genvar j = 0; j < NRP; j++) begin : g_rd
      logic [AW-1:0] ra;
      logic          fwd;
      assign ra  = bus.rd_addr[j*AW +: AW];
      assign fwd = BYPASS && wr_hit[ra];
      assign bus.rd_data[j*XLEN +: XLEN] = (ra == '0) ? '0 :
                                           fwd        ? wr_val[ra] : regs[ra];
      assign bus.rd_busy[j] = (ra != '0) && busy[ra] &&
                              !(fwd && !(bus.alloc_en && (bus.alloc_addr == ra)));
   end
endmodule
